// File: rtl/hex2ascii_pkg.sv
// ============================================================================
// Module   : hex2ascii_pkg
// Purpose  : Shared state encoding, ASCII constants and nibble-to-ASCII helper
// Revision : 1.0
// ============================================================================
`default_nettype none

package hex2ascii_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    DIG  = 3'd3,
    CR   = 3'd4,
    LF   = 3'd5
  } state_t;

  localparam logic [6:0] ASC_0  = 7'h30;
  localparam logic [6:0] ASC_X  = 7'h78;
  localparam logic [6:0] ASC_UA = 7'h41;
  localparam logic [6:0] ASC_LA = 7'h61;
  localparam logic [6:0] ASC_CR = 7'h0D;
  localparam logic [6:0] ASC_LF = 7'h0A;

  // Largest result is 'f' (0x66), so 7-bit arithmetic cannot wrap.
  function automatic logic [6:0] nib2asc(input logic [3:0] nib, input logic lower);
    logic [6:0] n7;
    n7 = {3'b000, nib};
    if (nib < 4'd10) begin
      return ASC_0 + n7;
    end
    return (lower ? ASC_LA : ASC_UA) + n7 - 7'd10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex2ascii_stream_if.sv
// ============================================================================
// Module   : hex2ascii_stream_if
// Purpose  : Word-in / character-out handshake bundle for hex2ascii_stream
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hex2ascii_stream_if #(
  parameter int DATA_W = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              lower_case;
  logic              out_valid;
  logic              out_ready;
  logic [6:0]        out_char;
  logic              out_last;
  logic              busy;

  modport master (
    output in_valid, in_data, lower_case, out_ready,
    input  in_ready, out_valid, out_char, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, lower_case, out_ready,
    output in_ready, out_valid, out_char, out_last, busy
  );

endinterface

`default_nettype wire

// File: rtl/hex2ascii_nib.sv
// ============================================================================
// Module   : hex2ascii_nib
// Purpose  : Combinational 4-bit nibble to 7-bit ASCII hex digit mapper
// Revision : 1.0
// ============================================================================
`default_nettype none

module hex2ascii_nib
  import hex2ascii_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_lower,
  output logic [6:0] o_char
);

  assign o_char = nib2asc(i_nib, i_lower);

endmodule

`default_nettype wire

// File: rtl/hex2ascii_stream.sv
// ============================================================================
// Module   : hex2ascii_stream
// Purpose  : Handshaked serializer emitting a word as ASCII hex, MSB first
// Revision : 1.0
// ============================================================================
`default_nettype none

module hex2ascii_stream
  import hex2ascii_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PREFIX_EN = 1,
  parameter int TERM_EN   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  hex2ascii_stream_if.slave  bus
);

  localparam int NIBBLES = DATA_W / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  generate
    if ((DATA_W < 4) || (DATA_W > 64) || ((DATA_W % 4) != 0)) begin : g_bad_width
      $error("hex2ascii_stream: DATA_W must be a multiple of 4 in 4..64");
    end
  endgenerate

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              r_lower;
  logic              w_lower_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_out_valid;
  logic              w_valid_nxt;
  logic [6:0]        r_out_char;
  logic [6:0]        w_char_nxt;
  logic              r_out_last;
  logic              w_last_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              w_adv;
  logic [3:0]        w_nibs [NIBBLES];
  logic [3:0]        w_nib;
  logic [6:0]        w_dig_char;

  assign w_adv = r_out_valid & bus.out_ready;

  // The digit mux looks at next-cycle data/counter so the registered
  // character is ready the cycle after accept even without a prefix.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib_split
      assign w_nibs[gi] = w_data_nxt[gi*4 +: 4];
    end
  endgenerate

  assign w_nib = w_nibs[w_cnt_nxt];

  hex2ascii_nib u_nib (
    .i_nib   (w_nib),
    .i_lower (w_lower_nxt),
    .o_char  (w_dig_char)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_lower_nxt = r_lower;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_data_nxt  = bus.in_data;
          w_lower_nxt = bus.lower_case;
          w_cnt_nxt   = CNT_W'(NIBBLES - 1);
          w_state_nxt = (PREFIX_EN != 0) ? P0 : DIG;
        end
      end
      P0:  if (w_adv) w_state_nxt = P1;
      P1:  if (w_adv) w_state_nxt = DIG;
      DIG: begin
        if (w_adv) begin
          if (r_cnt == '0) begin
            w_state_nxt = (TERM_EN != 0) ? CR : IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      CR:  if (w_adv) w_state_nxt = LF;
      LF:  if (w_adv) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_valid_nxt = (w_state_nxt != IDLE);
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_char_nxt  = 7'h00;
    w_last_nxt  = 1'b0;
    case (w_state_nxt)
      P0:  w_char_nxt = ASC_0;
      P1:  w_char_nxt = ASC_X;
      DIG: begin
        w_char_nxt = w_dig_char;
        w_last_nxt = (TERM_EN == 0) && (w_cnt_nxt == '0);
      end
      CR:  w_char_nxt = ASC_CR;
      LF: begin
        w_char_nxt = ASC_LF;
        w_last_nxt = 1'b1;
      end
      default: w_char_nxt = 7'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_lower     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_char  <= 7'h00;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_lower     <= w_lower_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_char  <= w_char_nxt;
      r_out_last  <= w_last_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_char  = r_out_char;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_hex2ascii_stream.sv
// ============================================================================
// Module   : tb_hex2ascii_stream
// Purpose  : Directed self-checking bench for hex2ascii_stream (3 configs)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hex2ascii_stream;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  hex2ascii_stream_if #(.DATA_W(16)) b16 ();
  hex2ascii_stream_if #(.DATA_W(8))  b8  ();
  hex2ascii_stream_if #(.DATA_W(64)) b64 ();

  hex2ascii_stream #(.DATA_W(16), .PREFIX_EN(1), .TERM_EN(1)) u_dut16 (
    .clk (clk), .rst_n (rst_n), .bus (b16)
  );
  hex2ascii_stream #(.DATA_W(8), .PREFIX_EN(0), .TERM_EN(0)) u_dut8 (
    .clk (clk), .rst_n (rst_n), .bus (b8)
  );
  hex2ascii_stream #(.DATA_W(64), .PREFIX_EN(1), .TERM_EN(1)) u_dut64 (
    .clk (clk), .rst_n (rst_n), .bus (b64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic g_valid(int sel);
    case (sel)
      0: return b16.out_valid;
      1: return b8.out_valid;
      default: return b64.out_valid;
    endcase
  endfunction

  function automatic logic [6:0] g_char(int sel);
    case (sel)
      0: return b16.out_char;
      1: return b8.out_char;
      default: return b64.out_char;
    endcase
  endfunction

  function automatic logic g_last(int sel);
    case (sel)
      0: return b16.out_last;
      1: return b8.out_last;
      default: return b64.out_last;
    endcase
  endfunction

  function automatic logic g_rdy(int sel);
    case (sel)
      0: return b16.in_ready;
      1: return b8.in_ready;
      default: return b64.in_ready;
    endcase
  endfunction

  function automatic logic g_busy(int sel);
    case (sel)
      0: return b16.busy;
      1: return b8.busy;
      default: return b64.busy;
    endcase
  endfunction

  task automatic set_in(int sel, logic v, logic [63:0] d, logic lc);
    case (sel)
      0: begin b16.in_valid = v; b16.in_data = d[15:0]; b16.lower_case = lc; end
      1: begin b8.in_valid  = v; b8.in_data  = d[7:0];  b8.lower_case  = lc; end
      default: begin b64.in_valid = v; b64.in_data = d; b64.lower_case = lc; end
    endcase
  endtask

  task automatic set_ordy(int sel, logic v);
    case (sel)
      0: b16.out_ready = v;
      1: b8.out_ready  = v;
      default: b64.out_ready = v;
    endcase
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_checks(int sel, string tag);
    chk({tag, " out_valid"}, 64'(g_valid(sel)), 64'd0);
    chk({tag, " out_last"},  64'(g_last(sel)),  64'd0);
    chk({tag, " busy"},      64'(g_busy(sel)),  64'd0);
    chk({tag, " in_ready"},  64'(g_rdy(sel)),   64'd1);
  endtask

  // Called on a falling edge; the accept happens on the following rising edge.
  task automatic send(int sel, logic [63:0] d, logic lc, string tag);
    chk({tag, " in_ready before accept"}, 64'(g_rdy(sel)), 64'd1);
    set_in(sel, 1'b1, d, lc);
    @(negedge clk);
    set_in(sel, 1'b0, 64'd0, 1'b0);
  endtask

  // mode[0]: random out_ready stalls; mode[1]: noise on in_valid/in_data/lower_case.
  task automatic expect_stream(int sel, string s, int nchars, int mode, string tag);
    int   i;
    int   cyc;
    logic rdy;
    byte  c;
    i   = 0;
    cyc = 0;
    while ((i < nchars) && (cyc < 400)) begin
      c = s[i];
      chk({tag, " out_valid"}, 64'(g_valid(sel)), 64'd1);
      chk({tag, " out_char"},  64'(g_char(sel)),  64'(c[6:0]));
      chk({tag, " out_last"},  64'(g_last(sel)),  64'(i == s.len() - 1));
      chk({tag, " in_ready busy"}, 64'(g_rdy(sel)), 64'd0);
      chk({tag, " busy"},      64'(g_busy(sel)),  64'd1);
      rdy = mode[0] ? 1'($urandom_range(0, 1)) : 1'b1;
      set_ordy(sel, rdy);
      if (mode[1]) begin
        set_in(sel, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
      if (rdy) i++;
      @(negedge clk);
      cyc++;
    end
    if (i < nchars) chk({tag, " timeout chars"}, 64'(i), 64'(nchars));
    set_in(sel, 1'b0, 64'd0, 1'b0);
    set_ordy(sel, 1'b1);
    if (nchars == s.len()) idle_checks(sel, {tag, " end"});
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    for (int s = 0; s < 3; s++) begin
      set_in(s, 1'b0, 64'd0, 1'b0);
      set_ordy(s, 1'b1);
    end
    repeat (2) @(negedge clk);
    idle_checks(0, "reset");
    chk("reset out_char", 64'(g_char(0)), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: upper case, full stream, no stalls
    send(0, 64'h1A2F, 1'b0, "t1");
    expect_stream(0, "0x1A2F\015\012", 8, 0, "t1");

    // 2: lower case, lower_case/in_valid noise mid-word
    send(0, 64'h1A2F, 1'b1, "t2");
    expect_stream(0, "0x1a2f\015\012", 8, 2, "t2");

    // 3: random stalls plus in_valid pulses while busy
    send(0, 64'h1A2F, 1'b0, "t3");
    expect_stream(0, "0x1A2F\015\012", 8, 3, "t3");
    @(negedge clk);
    idle_checks(0, "t3 no stray accept");

    // 4: 8-bit, no prefix/terminator, back-to-back with held in_valid
    chk("t4 in_ready", 64'(g_rdy(1)), 64'd1);
    set_in(1, 1'b1, 64'h00, 1'b0);
    @(negedge clk);
    chk("t4 c0 valid", 64'(g_valid(1)), 64'd1);
    chk("t4 c0 char",  64'(g_char(1)),  64'h30);
    chk("t4 c0 last",  64'(g_last(1)),  64'd0);
    chk("t4 c0 in_ready", 64'(g_rdy(1)), 64'd0);
    @(negedge clk);
    chk("t4 c1 char",  64'(g_char(1)),  64'h30);
    chk("t4 c1 last",  64'(g_last(1)),  64'd1);
    @(negedge clk);
    idle_checks(1, "t4 bubble");
    set_in(1, 1'b1, 64'hA5, 1'b0);
    @(negedge clk);
    set_in(1, 1'b0, 64'd0, 1'b0);
    expect_stream(1, "A5", 2, 0, "t4b");

    // 5: 64-bit word, 20 characters
    send(2, 64'hFEDC_BA98_7654_3210, 1'b0, "t5");
    expect_stream(2, "0xFEDCBA9876543210\015\012", 20, 0, "t5");

    // 6: asynchronous reset after the third character
    send(0, 64'h1A2F, 1'b0, "t6");
    expect_stream(0, "0x1A2F\015\012", 3, 0, "t6a");
    #2 rst_n = 1'b0;
    #1;
    idle_checks(0, "t6 async reset");
    chk("t6 out_char reset", 64'(g_char(0)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_checks(0, "t6 after release");
    send(0, 64'h00B7, 1'b0, "t6b");
    expect_stream(0, "0x00B7\015\012", 8, 0, "t6b");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hex2ascii_stream.md
Name: hex2ascii_stream

Overview:
Parametrised, handshaked hex-to-ASCII serializer. Accepts one DATA_W-bit word and emits its hexadecimal text one 7-bit ASCII character per transfer, MSB nibble first. The word can carry an optional "0x" prefix and an optional CR/LF terminator, and digits can be upper or lower case. It sits between a data source and a UART or character-sink stage.

Parameters:
DATA_W, 16, input word width; multiple of 4, range 4..64; other values are rejected at elaboration.
PREFIX_EN, 1, 1 = emit "0x" (0x30, 0x78) before the digits.
TERM_EN, 1, 1 = emit CR (0x0D) then LF (0x0A) after the digits.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  in_data/lower_case are valid.
in_ready  out  1  block can accept a word; equals (state==IDLE).
in_data  in  DATA_W  word to convert.
lower_case  in  1  1 = digits a-f, 0 = A-F; sampled only at accept.
out_valid  out  1  out_char is valid.
out_ready  in  1  sink accepts out_char.
out_char  out  7  ASCII character.
out_last  out  1  out_char is the final character of the current word.
busy  out  1  high from the accept cycle until the final character handshake.

Behaviour:
- Single clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_char=0, out_last=0, busy=0. Data, case and counter registers are cleared to 0.
- Accept: in_valid & in_ready at an edge. At that edge the block latches in_data and lower_case, loads the nibble counter with NIBBLES-1, and sets busy=1.
- Latency: the first character has out_valid=1 in the cycle after accept.
- out_char, out_valid and out_last are registered.
- Transfer: out_valid & out_ready advances to the next character at that edge.
- Stall: while out_valid=1 and out_ready=0, out_char and out_last must hold stable.
- FSM states and transitions:
  - IDLE -> P0 if PREFIX_EN, else DIG.
  - P0 ('0') -> P1 ('x') -> DIG.
  - DIG: counter decrements per transfer. At count 0 -> CR if TERM_EN, else IDLE.
  - CR -> LF -> IDLE.
- Digit mapping: n<10 -> 0x30+n. n>=10 -> 0x41+(n-10) when upper case, 0x61+(n-10) when lower case. Arithmetic is 7 bits wide and never overflows.
- Characters per word = NIBBLES + 2*PREFIX_EN + 2*TERM_EN.
- out_last=1 on the final character only: LF if TERM_EN, else the last digit.
- End of word: on the final handshake the next state is IDLE, out_valid=0 and busy=0. in_ready=1 in the following cycle, so there is one bubble cycle; there is no same-cycle re-accept.
- in_valid while busy is ignored. The source must hold its data, because in_ready=0.
- Leading zeros are always emitted; no suppression.
- Reset mid-word: the word is dropped immediately, all outputs take their reset values, and no partial continuation occurs after release.
- lower_case changing mid-word has no effect.

Decomposition:
- Package hex2ascii_pkg holds:
  - state enum {IDLE,P0,P1,DIG,CR,LF};
  - constants ASC_0=7'h30, ASC_X=7'h78, ASC_UA=7'h41, ASC_LA=7'h61, ASC_CR=7'h0D, ASC_LF=7'h0A;
  - function nib2asc(nib, lower).
- One sub-module is natural: hex2ascii_nib, a combinational 4-bit -> 7-bit mapper with a lower_case input. It is instantiated once and fed by a nibble mux indexed by the counter.

Test Plan:
1. DATA_W=16, PREFIX/TERM=1, in_data=16'h1A2F, lower_case=0, out_ready=1 -> stream 0x30,0x78,0x31,0x41,0x32,0x46,0x0D,0x0A over 8 consecutive cycles starting 1 cycle after accept; out_last only on 0x0A; in_ready returns 1 the cycle after.
2. Same word with lower_case=1 -> digits 0x31,0x61,0x32,0x66; lower_case toggled mid-word has no effect.
3. out_ready toggled 1/0 randomly -> out_char and out_last stay stable while stalled; character sequence identical to case 1; in_valid pulses while busy are not accepted.
4. PREFIX_EN=0, TERM_EN=0, DATA_W=8, in_data=8'h00 -> exactly 0x30,0x30 with out_last on the second; back-to-back words show a one-cycle in_ready bubble.
5. DATA_W=64, in_data=64'hFEDC_BA98_7654_3210 -> 16 digits in order F..0 (upper case), 20 characters total with prefix and terminator.
6. rst_n asserted asynchronously after the 3rd character -> outputs go to reset values immediately without a clock edge; after release a new word starts cleanly from '0'.
